// File: rtl/conv_egress.sv
// Egress FIFO + AXI4-Stream master for the convolution engine, with early stall toward the pipeline.
// Optional line/frame checker compiled in with `define CONV_EGRESS_CHECK_EN.
package conv_pkg;
  localparam int PIXEL_W = 8;
  typedef logic [PIXEL_W-1:0] pixel_t;
endpackage

module conv_egress #(
  parameter int DEPTH     = 8,
  parameter int STALL_LAT = 3
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        res_vld_i,
  input  logic [conv_pkg::PIXEL_W-1:0] res_data_i,
  input  logic                        res_sof_i,
  input  logic                        res_eol_i,
  output logic                        res_stall_o,
  output logic                        m_tvalid_o,
  output logic [conv_pkg::PIXEL_W-1:0] m_tdata_o,
  output logic                        m_tuser_o,
  output logic                        m_tlast_o,
  input  logic                        m_tready_i,
  output logic [2:0]                  err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - STALL_LAT);

  typedef struct packed {
    logic                         sof;
    logic                         eol;
    logic [conv_pkg::PIXEL_W-1:0] data;
  } entry_t;

  entry_t      mem [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        empty, full, push, pop, ovf;
  logic        err_ovf, err_len, err_sof;

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign pop   = ~empty & m_tready_i;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept while draining.
  assign push  = res_vld_i & (~full | pop);
  assign ovf   = res_vld_i & full & ~pop;

  // NOTE: storage has no reset; the empty mask on the outputs hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= entry_t'{sof: res_sof_i, eol: res_eol_i, data: res_data_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (ovf)  err_ovf <= 1'b1;
    end
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign m_tvalid_o  = ~empty;
  assign m_tdata_o   = empty ? '0 : head.data;
  assign m_tuser_o   = ~empty & head.sof;
  assign m_tlast_o   = ~empty & head.eol;
  assign res_stall_o = (count >= STALL_TH);

`ifdef CONV_EGRESS_CHECK_EN
  logic [15:0] col, line_len, col_len;
  logic        len_vld, armed;

  // A pushed SOF discards any latched length so the first line of the new frame sets it.
  assign col_len = col + 16'd1;
  assign armed   = len_vld & ~res_sof_i;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      col      <= '0;
      line_len <= '0;
      len_vld  <= 1'b0;
      err_len  <= 1'b0;
      err_sof  <= 1'b0;
    end else if (push) begin
      if (res_sof_i && col != '0) err_sof <= 1'b1;
      if (res_sof_i) len_vld <= 1'b0;
      if (res_eol_i) begin
        col <= '0;
        if (armed && col_len != line_len) err_len <= 1'b1;
        if (!armed) begin
          line_len <= col_len;
          len_vld  <= 1'b1;
        end
      end else begin
        col <= col_len;
      end
    end
  end
`else
  assign err_len = 1'b0;
  assign err_sof = 1'b0;
`endif

  assign err_o = {err_sof, err_len, err_ovf};
endmodule

// File: tb/tb_conv_egress.sv
// Self-checking bench for conv_egress: directed scenarios plus randomized traffic against a queue model.
// Expectations for err_o[2:1] follow whether CONV_EGRESS_CHECK_EN is defined.
module tb_conv_egress;
  localparam int DEPTH     = 8;
  localparam int STALL_LAT = 3;
  localparam int PW        = conv_pkg::PIXEL_W;
`ifdef CONV_EGRESS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [PW+1:0] beat_t;  // {sof, eol, data}

  logic          clk = 1'b0, arst_n = 1'b0;
  logic          res_vld_i = 1'b0, res_sof_i = 1'b0, res_eol_i = 1'b0, m_tready_i = 1'b0;
  logic [PW-1:0] res_data_i = '0, m_tdata_o;
  logic          res_stall_o, m_tvalid_o, m_tuser_o, m_tlast_o;
  logic [2:0]    err_o;

  conv_egress #(.DEPTH(DEPTH), .STALL_LAT(STALL_LAT)) dut (
    .clk(clk), .arst_n(arst_n), .res_vld_i(res_vld_i), .res_data_i(res_data_i),
    .res_sof_i(res_sof_i), .res_eol_i(res_eol_i), .res_stall_o(res_stall_o),
    .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o), .m_tuser_o(m_tuser_o),
    .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0, n_bad = 0;
  beat_t exp_q[$], exp_pop_q[$], obs_q[$];
  bit    m_ovf, m_elen, m_esof, m_have_len;
  int    m_col, m_len;

  function automatic logic [2:0] m_err();
    return {m_esof, m_elen, m_ovf};
  endfunction

  task automatic model_reset();
    exp_q.delete(); exp_pop_q.delete(); obs_q.delete();
    m_ovf = 0; m_elen = 0; m_esof = 0; m_have_len = 0; m_col = 0; m_len = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_vld_i = 1'b0; m_tready_i = 1'b0;
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // One clock: drive at the falling edge, log the beat the DUT hands over, advance the model.
  task automatic cycle(input logic vld, input logic [PW-1:0] d, input logic sof,
                       input logic eol, input logic rdy);
    bit pop, push;
    res_vld_i = vld; res_data_i = d; res_sof_i = sof; res_eol_i = eol; m_tready_i = rdy;
    if (m_tvalid_o && rdy) obs_q.push_back({m_tuser_o, m_tlast_o, m_tdata_o});
    pop  = (exp_q.size() != 0) && rdy;
    push = vld && (exp_q.size() < DEPTH || pop);
    if (vld && !push) m_ovf = 1;
    if (pop) exp_pop_q.push_back(exp_q.pop_front());
    if (push) begin
      exp_q.push_back({sof, eol, d});
      if (CHK) begin
        if (sof && m_col != 0) m_esof = 1;
        if (sof) m_have_len = 0;
        if (eol) begin
          if (m_have_len && m_col + 1 != m_len) m_elen = 1;
          if (!m_have_len) begin m_len = m_col + 1; m_have_len = 1; end
          m_col = 0;
        end else m_col++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 4*DEPTH && exp_q.size() != 0; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (m_tvalid_o !== 1'b0) begin
      n_bad++; $display("FAIL drain_empty: m_tvalid_o=%b required 0", m_tvalid_o);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o} !== '0) begin
      n_bad++; $display("FAIL reset_axis: valid=%b data=%h user=%b last=%b required all 0",
                        m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o);
    end
    n_cmp++;
    if ({res_stall_o, err_o} !== 4'b0) begin
      n_bad++; $display("FAIL reset_status: stall=%b err=%b required 0/000", res_stall_o, err_o);
    end
    @(negedge clk); arst_n = 1'b1; model_reset(); @(negedge clk);
  endtask

  task automatic test_single();
    beat_t want;
    cycle(1'b1, PW'(8'h5A), 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({m_tvalid_o, m_tuser_o, m_tdata_o} !== {1'b1, 1'b1, PW'(8'h5A)}) begin
      n_bad++; $display("FAIL single_beat: valid=%b user=%b data=%h required 1/1/5a",
                        m_tvalid_o, m_tuser_o, m_tdata_o);
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (m_tvalid_o !== 1'b0 || err_o !== 3'b0) begin
      n_bad++; $display("FAIL single_after: valid=%b err=%b required 0/000", m_tvalid_o, err_o);
    end
    want = {1'b1, 1'b0, PW'(8'h5A)};
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== want) begin
      n_bad++; $display("FAIL single_count: beats=%0d required 1 of %h", obs_q.size(), want);
    end
  endtask

  task automatic test_stream();
    logic [PW-1:0] pix [24];
    int stall_hits = 0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      pix[i] = PW'($urandom);
      cycle(1'b1, pix[i], i == 0, (i % 6) == 5, 1'b1);
      if (res_stall_o !== 1'b0) stall_hits++;
    end
    drain();
    n_cmp++;
    if (stall_hits != 0) begin
      n_bad++; $display("FAIL stream_stall: stall seen %0d cycles required 0", stall_hits);
    end
    n_cmp++;
    if (obs_q.size() != 24) begin
      n_bad++; $display("FAIL stream_count: beats=%0d required 24", obs_q.size());
    end
    for (int i = 0; i < 24 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== {i == 0, (i % 6) == 5, pix[i]}) begin
        n_bad++; $display("FAIL stream_beat%0d: got %h required %h", i, obs_q[i],
                          {i == 0, (i % 6) == 5, pix[i]});
      end
    end
  endtask

  // Fill with ready low; optionally push one extra pixel into the full FIFO.
  task automatic test_fill(input bit extra);
    logic [PW-1:0] pix [9];
    int n = extra ? 9 : 8;
    do_reset();
    for (int i = 0; i < n; i++) begin
      pix[i] = PW'($urandom);
      cycle(1'b1, pix[i], 1'b0, 1'b0, 1'b0);
      if (i < 5) begin
        n_cmp++;
        if (res_stall_o !== (i == 4)) begin
          n_bad++; $display("FAIL fill_stall_push%0d: stall=%b required %b", i + 1, res_stall_o, i == 4);
        end
      end
    end
    n_cmp++;
    if (err_o[0] !== extra || res_stall_o !== 1'b1 || m_tvalid_o !== 1'b1) begin
      n_bad++; $display("FAIL fill_full: ovf=%b stall=%b valid=%b required %b/1/1",
                        err_o[0], res_stall_o, m_tvalid_o, extra);
    end
    drain();
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_bad++; $display("FAIL fill_count: beats=%0d required 8", obs_q.size());
    end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i][PW-1:0] !== pix[i]) begin
        n_bad++; $display("FAIL fill_beat%0d: got %h required %h", i, obs_q[i][PW-1:0], pix[i]);
      end
    end
    n_cmp++;
    if (err_o[0] !== extra || res_stall_o !== 1'b0) begin
      n_bad++; $display("FAIL fill_sticky: ovf=%b stall=%b required %b/0", err_o[0], res_stall_o, extra);
    end
  endtask

  task automatic test_checker();
    int lens [3] = '{6, 6, 5};
    do_reset();
    foreach (lens[l]) begin
      for (int c = 0; c < lens[l]; c++)
        cycle(1'b1, PW'($urandom), l == 0 && c == 0, c == lens[l] - 1, 1'b1);
      n_cmp++;
      if (err_o[1] !== (l == 2 ? CHK : 1'b0)) begin
        n_bad++; $display("FAIL chk_len_line%0d: err1=%b required %b", l, err_o[1], l == 2 ? CHK : 1'b0);
      end
    end
    drain();
    do_reset();
    for (int c = 0; c < 3; c++) cycle(1'b1, PW'($urandom), c == 0, 1'b0, 1'b1);
    n_cmp++;
    if (err_o[2] !== 1'b0) begin
      n_bad++; $display("FAIL chk_sof_before: err2=%b required 0", err_o[2]);
    end
    cycle(1'b1, PW'($urandom), 1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (err_o !== {CHK, 2'b00}) begin
      n_bad++; $display("FAIL chk_sof_col3: err=%b required %b", err_o, {CHK, 2'b00});
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, PW'($urandom), 1'b0, 1'b0, 1'b0);
    res_vld_i = 1'b0;
    n_cmp++;
    if (m_tvalid_o !== 1'b1) begin
      n_bad++; $display("FAIL midrst_held: valid=%b required 1", m_tvalid_o);
    end
    #2 arst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o, res_stall_o, err_o} !== '0) begin
      n_bad++; $display("FAIL midrst_async: valid=%b data=%h stall=%b err=%b required all 0",
                        m_tvalid_o, m_tdata_o, res_stall_o, err_o);
    end
    model_reset();
    @(negedge clk); arst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (m_tvalid_o !== 1'b0 || err_o !== 3'b0 || obs_q.size() != 0) begin
      n_bad++; $display("FAIL midrst_after: valid=%b err=%b beats=%0d required 0/000/0",
                        m_tvalid_o, err_o, obs_q.size());
    end
  endtask

  task automatic test_random();
    int bad_before = n_bad;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      n_cmp++;
      if (m_tvalid_o !== (exp_q.size() != 0) || res_stall_o !== (exp_q.size() >= DEPTH - STALL_LAT)
          || err_o !== m_err()) begin
        n_bad++; $display("FAIL rand_status@%0d: valid=%b stall=%b err=%b required %b/%b/%b (occ %0d)",
                          i, m_tvalid_o, res_stall_o, err_o, exp_q.size() != 0,
                          exp_q.size() >= DEPTH - STALL_LAT, m_err(), exp_q.size());
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if ({m_tuser_o, m_tlast_o, m_tdata_o} !== exp_q[0]) begin
          n_bad++; $display("FAIL rand_head@%0d: got %h required %h", i,
                            {m_tuser_o, m_tlast_o, m_tdata_o}, exp_q[0]);
        end
      end
      if (n_bad - bad_before > 10) break;
      cycle(res_stall_o ? ($urandom % 8 == 0) : ($urandom % 4 != 0), PW'($urandom),
            $urandom % 16 == 0, $urandom % 6 == 0, $urandom % 3 != 0);
    end
    drain();
    n_cmp++;
    if (obs_q.size() != exp_pop_q.size()) begin
      n_bad++; $display("FAIL rand_count: beats=%0d required %0d", obs_q.size(), exp_pop_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_pop_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_pop_q[i]) begin
        n_bad++; $display("FAIL rand_beat%0d: got %h required %h", i, obs_q[i], exp_pop_q[i]);
        break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_fill(1'b0);
    test_fill(1'b1);
    test_checker();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
